shift_bus_master: RTL and testbench

SHIFT_BUS_MASTER -- requirements
Module: shift_bus_master

---
 rtl/shift_bus_master.sv | 206 ++++++++++++++++++++
 tb/tb_shift_bus_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_bus_master.sv
// -----------------------------------------------------------------------------
// shift_bus_master
//
// Drives a register-mapped shift peripheral through one complete transaction
// per accepted start: write the config word, write the operand, poll the
// status register until its done flag is set (or give up), read back the
// result, then report completion.
//
// Ports
//   clk          single clock, everything on the rising edge
//   reset        synchronous, active-low
//   start        one-cycle request, looked at only while idle
//   dir          0 = shift left, 1 = shift right (captured with start)
//   amount       shift count 0..15 (captured with start)
//   operand      value to shift (captured with start)
//   busy         high while a transaction is on the bus
//   done         one-cycle pulse, result is valid
//   error        one-cycle pulse, status poll timed out, result untouched
//   result       last value read back from the peripheral
//   bus_cs       peripheral chip select
//   bus_we       peripheral write enable, only ever high together with bus_cs
//   bus_reg_sel  00 config, 01 operand, 10 result, 11 status
//   bus_wdata    write data, zero whenever no write is in progress
//   bus_rdata    peripheral read data; status done flag is bit 0
//   state_dbg    current FSM state, for observation only
//
// Handshake: start is a single-cycle request that is accepted only in IDLE;
// a start seen in any other state is dropped, nothing is queued. Each
// accepted start produces exactly one single-cycle done or error pulse (never
// both), unless reset intervenes, in which case neither is produced.
// -----------------------------------------------------------------------------
module shift_bus_master #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic [3:0]    amount,
    input  logic [DW-1:0] operand,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [DW-1:0] result,
    output logic          bus_cs,
    output logic          bus_we,
    output logic [1:0]    bus_reg_sel,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_CFG = 3'd1,
        WR_OPR = 3'd2,
        POLL   = 3'd3,
        RD_RES = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [1:0] SEL_CFG    = 2'b00;
    localparam logic [1:0] SEL_OPR    = 2'b01;
    localparam logic [1:0] SEL_RES    = 2'b10;
    localparam logic [1:0] SEL_STATUS = 2'b11;

    // Counter value seen on the last permitted POLL cycle.
    localparam logic [7:0] POLL_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;

    logic          cmd_dir;
    logic [3:0]    cmd_amount;
    logic [DW-1:0] cmd_operand;
    logic [7:0]    poll_cnt;
    logic          timed_out;
    logic [DW-1:0] cfg_word;

    wire status_ready = bus_rdata[0];
    wire poll_expired = (poll_cnt == POLL_LAST);

    assign state_dbg = state;

    // Config register layout: direction at bit 8, shift count at bits 3:0.
    always_comb begin
        cfg_word        = '0;
        cfg_word[8]     = cmd_dir;
        cfg_word[3:0]   = cmd_amount;
    end

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_dir     <= 1'b0;
            cmd_amount  <= '0;
            cmd_operand <= '0;
            poll_cnt    <= '0;
            timed_out   <= 1'b0;
            result      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // Command registers are loaded only here, so input
                    // activity during a transaction cannot disturb them.
                    if (start) begin
                        cmd_dir     <= dir;
                        cmd_amount  <= amount;
                        cmd_operand <= operand;
                        timed_out   <= 1'b0;
                    end
                end
                WR_OPR: begin
                    poll_cnt <= '0;
                end
                POLL: begin
                    if (!status_ready) begin
                        if (poll_expired) begin
                            timed_out <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 8'd1;
                        end
                    end
                end
                RD_RES: begin
                    result <= bus_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = WR_CFG;
            WR_CFG:  state_next = WR_OPR;
            WR_OPR:  state_next = POLL;
            POLL: begin
                if (status_ready) begin
                    state_next = RD_RES;
                end else if (poll_expired) begin
                    state_next = FIN;
                end
            end
            RD_RES:  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the current state only
    // -------------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        bus_cs      = 1'b0;
        bus_we      = 1'b0;
        bus_reg_sel = SEL_CFG;
        bus_wdata   = '0;
        case (state)
            WR_CFG: begin
                busy        = 1'b1;
                bus_cs      = 1'b1;
                bus_we      = 1'b1;
                bus_reg_sel = SEL_CFG;
                bus_wdata   = cfg_word;
            end
            WR_OPR: begin
                busy        = 1'b1;
                bus_cs      = 1'b1;
                bus_we      = 1'b1;
                bus_reg_sel = SEL_OPR;
                bus_wdata   = cmd_operand;
            end
            POLL: begin
                busy        = 1'b1;
                bus_cs      = 1'b1;
                bus_reg_sel = SEL_STATUS;
            end
            RD_RES: begin
                busy        = 1'b1;
                bus_cs      = 1'b1;
                bus_reg_sel = SEL_RES;
            end
            FIN: begin
                done  = !timed_out;
                error = timed_out;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shift_bus_master.sv
module tb_shift_bus_master;

  localparam int DW      = 16;
  localparam int TIMEOUT = 32;
  localparam int NEVER   = 255;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [3:0]    amount = '0;
  logic [DW-1:0] operand = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] result;
  logic          bus_cs;
  logic          bus_we;
  logic [1:0]    bus_reg_sel;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  shift_bus_master #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .amount     (amount),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .result     (result),
    .bus_cs     (bus_cs),
    .bus_we     (bus_we),
    .bus_reg_sel(bus_reg_sel),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic          err_q[$];
  logic [DW-1:0] cfg_q[$];
  logic [DW-1:0] opr_q[$];
  logic [DW-1:0] model_result = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Peripheral model: latches written config/operand, counts status polls,
  // answers reads combinationally from bus_reg_sel.
  // ---------------------------------------------------------------------------
  int            ready_after = 0;
  int            poll_seen = 0;
  logic [DW-1:0] p_cfg = '0;
  logic [DW-1:0] p_opr = '0;
  logic [DW-1:0] p_shifted;

  assign p_shifted = p_cfg[8] ? (p_opr >> p_cfg[3:0]) : (p_opr << p_cfg[3:0]);

  always @(posedge clk) begin
    if (bus_cs && bus_we && bus_reg_sel == 2'b00) begin
      p_cfg     <= bus_wdata;
      poll_seen <= 0;
    end else if (bus_cs && bus_we && bus_reg_sel == 2'b01) begin
      p_opr <= bus_wdata;
    end else if (bus_cs && !bus_we && bus_reg_sel == 2'b11) begin
      poll_seen <= poll_seen + 1;
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_reg_sel)
      2'b11:   bus_rdata[0] = (poll_seen >= ready_after);
      2'b10:   bus_rdata = p_shifted;
      default: bus_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor: bus rules every cycle, pops the scoreboard on writes/completions
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    chk("we_without_cs", (bus_we && !bus_cs), 1'b0);
    chk("done_and_error", (done && error), 1'b0);
    if (!bus_we) chk("wdata_idle_zero", bus_wdata, '0);

    if (bus_cs && bus_we && bus_reg_sel == 2'b00) begin
      chk("cfg_write_expected", (cfg_q.size() > 0), 1'b1);
      if (cfg_q.size() > 0) chk("cfg_wdata", bus_wdata, cfg_q.pop_front());
    end
    if (bus_cs && bus_we && bus_reg_sel == 2'b01) begin
      chk("opr_write_expected", (opr_q.size() > 0), 1'b1);
      if (opr_q.size() > 0) chk("opr_wdata", bus_wdata, opr_q.pop_front());
    end
    if (done || error) begin
      chk("completion_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        chk("result", result, exp_q.pop_front());
        chk("error_kind", error, err_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // glitch > 0: pulse start (with different command values) in that cycle of
  // the transaction, and pulse start again in the FIN cycle.
  task automatic run_txn(input logic d, input logic [3:0] a, input logic [DW-1:0] op,
                         input int rdy, input int glitch);
    logic [DW-1:0] cfg_exp;
    logic          exp_err;
    int            lat;
    int            exp_lat;
    int            exp_polls;
    exp_err     = (rdy >= TIMEOUT);
    cfg_exp     = '0;
    cfg_exp[8]  = d;
    cfg_exp[3:0] = a;
    if (!exp_err) model_result = d ? (op >> a) : (op << a);
    exp_lat   = exp_err ? (3 + TIMEOUT) : (5 + rdy);
    exp_polls = exp_err ? TIMEOUT : (rdy + 1);

    @(posedge clk); #1;
    ready_after = rdy;
    start = 1'b1; dir = d; amount = a; operand = op;
    cfg_q.push_back(cfg_exp);
    opr_q.push_back(op);
    exp_q.push_back(model_result);
    err_q.push_back(exp_err);
    @(posedge clk); #1;
    start = 1'b0;

    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (done || error) break;
      chk("busy_during_txn", busy, 1'b1);
      if (lat == glitch) begin
        start = 1'b1; dir = ~d; amount = ~a; operand = ~op;
      end else begin
        start   = 1'b0;
        dir     = 1'($urandom_range(0, 1));
        amount  = 4'($urandom_range(0, 15));
        operand = DW'($urandom);
      end
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_at_fin", busy, 1'b0);
    chk("done_pulse", done, !exp_err);
    chk("error_pulse", error, exp_err);
    chk("poll_cycles", poll_seen, exp_polls);

    if (glitch > 0) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_fin_ignored", busy, 1'b0);
      chk("start_in_fin_cs", bus_cs, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_result"}, result, '0);
    chk({tag, "_cs"}, bus_cs, 1'b0);
    chk({tag, "_we"}, bus_we, 1'b0);
    chk({tag, "_sel"}, bus_reg_sel, 2'b00);
    chk({tag, "_wdata"}, bus_wdata, '0);
  endtask

  // Start a transaction and pull reset while the operand write is on the bus.
  task automatic abort_txn(input logic [DW-1:0] op);
    logic [DW-1:0] cfg_exp;
    cfg_exp    = '0;
    cfg_exp[3:0] = 4'd2;
    @(posedge clk); #1;
    ready_after = 0;
    start = 1'b1; dir = 1'b0; amount = 4'd2; operand = op;
    cfg_q.push_back(cfg_exp);
    opr_q.push_back(op);
    @(posedge clk); #1;                // WR_CFG
    start = 1'b0;
    @(posedge clk); #1;                // WR_OPR
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    chk("abort_in_wr_opr", (bus_we && bus_reg_sel == 2'b01), 1'b1);
    @(posedge clk); #1;
    check_reset_outputs("abort");
    reset = 1'b1;
    model_result = '0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_stays_idle", busy, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    run_txn(1'b0, 4'd1, 16'h0002, 0, 0);
    chk("left1_result", result, 16'h0004);

    run_txn(1'b1, 4'd4, 16'hF000, 3, 0);
    chk("right4_result", result, 16'h0F00);

    run_txn(1'b0, 4'd0, 16'hA5A5, 1, 0);
    chk("amount0_result", result, 16'hA5A5);

    run_txn(1'b0, 4'd3, 16'h1234, NEVER, 0);
    chk("timeout_result_kept", result, 16'hA5A5);

    run_txn(1'b1, 4'd2, 16'h8001, 3, 3);
    chk("glitch_result", result, 16'h2000);

    abort_txn(16'h00FF);

    run_txn(1'b0, 4'd15, 16'h0001, 2, 0);
    chk("after_abort_result", result, 16'h8000);

    for (int i = 0; i < 6; i++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom),
              $urandom_range(0, 5), 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("cfg_q_drained", cfg_q.size(), 0);
    chk("opr_q_drained", opr_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
